// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Purpose:
//   This is the upstream command stage for the FIFO/ALU pipeline. It accepts
//   one host operation at a time over a valid/ready handshake. It packs each
//   operation into the 10-bit word that the input FIFO expects:
//   {op[9:8], b[7:4], a[3:0]}.
//
//   Issue is throttled in two ways. A credit counter tracks the results still
//   outstanding downstream. The FIFO full flag is also obeyed. A spacing cycle
//   follows every issue, so the FIFO never sees back-to-back writes.
//
//   Divide-by-zero commands are rejected here and never reach the ALU. The
//   block keeps one count of issued commands and one count of rejected ones.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   host_valid  host offers a command
//   host_ready  block can accept a command (high only when idle)
//   host_op     operation: 0=add 1=sub 2=mul 3=div
//   host_a      operand a (data1)
//   host_b      operand b (data2)
//   cmd_data    packed command; holds its last issued value between issues
//   cmd_valid   one-cycle write strobe into the input FIFO
//   cmd_full    input FIFO full flag (only looked at while arbitrating)
//   result_ack  one-cycle pulse per drained result; returns one credit
//   credits     current credit count
//   err_div0    one-cycle pulse when a div-by-zero command is dropped
//   issued_cnt  issued command count, wraps
//   reject_cnt  rejected command count, saturates at 255
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int MAX_CREDITS = 7,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [1:0]       host_op,
    input  logic [3:0]       host_a,
    input  logic [3:0]       host_b,
    output logic [9:0]       cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_full,
    input  logic             result_ack,
    output logic [3:0]       credits,
    output logic             err_div0,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [7:0]       reject_cnt
);

    localparam logic [3:0] CRED_MAX = 4'(MAX_CREDITS);
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_GAP,
        S_REJECT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_host_ready;
    logic [9:0]         r_hold;
    logic [9:0]         r_cmd_data;
    logic               r_cmd_valid;
    logic               r_err_div0;
    logic [3:0]         r_credits;
    logic [CNT_W-1:0]   r_issued_cnt;
    logic [7:0]         r_reject_cnt;

    logic               w_xfer;
    logic               w_issue;
    logic               w_reject;

    // A transfer needs host_ready. host_ready is registered high only for
    // the IDLE state, so every transfer is seen from IDLE.
    assign w_xfer   = host_valid && r_host_ready;
    assign w_issue  = (r_state == S_ISSUE);
    assign w_reject = (r_state == S_REJECT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (host_op == OP_DIV && host_b == 4'd0) begin
                        w_state_next = S_REJECT;
                    end else begin
                        w_state_next = S_ARB;
                    end
                end
            end
            S_ARB: begin
                // Wait for a credit and for room in the FIFO. There is no
                // timeout: the host stays blocked until both hold.
                if (r_credits != 4'd0 && !cmd_full) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE:  w_state_next = S_GAP;
            S_GAP:    w_state_next = S_IDLE;
            S_REJECT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_host_ready <= 1'b1;
            r_hold       <= 10'd0;
            r_cmd_data   <= 10'd0;
            r_cmd_valid  <= 1'b0;
            r_err_div0   <= 1'b0;
            r_credits    <= CRED_MAX;
            r_issued_cnt <= '0;
            r_reject_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_host_ready <= (w_state_next == S_IDLE);

            if (w_xfer) begin
                r_hold <= {host_op, host_b, host_a};
            end

            // The strobes are registered from the next state, so each one
            // lines up exactly with the cycle spent in its state. cmd_data
            // loads only on entry to ISSUE. It then holds its value until
            // the next issue.
            r_cmd_valid <= (w_state_next == S_ISSUE);
            r_err_div0  <= (w_state_next == S_REJECT);
            if (w_state_next == S_ISSUE) begin
                r_cmd_data <= r_hold;
            end

            // An issue and an ack in the same cycle cancel out. An ack
            // that arrives when credits are already at the maximum is
            // dropped. ISSUE is entered only when a credit is available,
            // so the decrement cannot underflow.
            if (w_issue && !result_ack) begin
                r_credits <= r_credits - 4'd1;
            end else if (!w_issue && result_ack && r_credits != CRED_MAX) begin
                r_credits <= r_credits + 4'd1;
            end

            if (w_issue) begin
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            end

            if (w_reject && r_reject_cnt != 8'hFF) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
        end
    end

    assign host_ready = r_host_ready;
    assign cmd_data   = r_cmd_data;
    assign cmd_valid  = r_cmd_valid;
    assign err_div0   = r_err_div0;
    assign credits    = r_credits;
    assign issued_cnt = r_issued_cnt;
    assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
//
// Bench for alu_cmd_issuer. The reference model works in time, not states.
//
// For each accepted command it records the cycle of the transfer. A rejected
// command pulses err_div0 one cycle after its transfer. Any other command
// issues one cycle after the first cycle (counted from the transfer onward)
// in which a credit is free and the FIFO is not full. The host becomes ready
// again two cycles after the pulse.
//
// All waiting goes through step(). At every falling edge, step() compares
// every output with the model and then drives the next inputs.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int MAXC = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [1:0]  host_op = 2'd0;
    logic [3:0]  host_a = 4'd0;
    logic [3:0]  host_b = 4'd0;
    logic [9:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_full = 1'b0;
    logic        result_ack = 1'b0;
    logic [3:0]  credits;
    logic        err_div0;
    logic [15:0] issued_cnt;
    logic [7:0]  reject_cnt;

    alu_cmd_issuer #(.MAX_CREDITS(MAXC), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_op    (host_op),
        .host_a     (host_a),
        .host_b     (host_b),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_full   (cmd_full),
        .result_ack (result_ack),
        .credits    (credits),
        .err_div0   (err_div0),
        .issued_cnt (issued_cnt),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model, advanced on each rising edge
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic        m_busy = 1'b0;
    logic        m_rej = 1'b0;
    int          m_txfer = 0;
    int          m_tissue = 0;      // 0 = issue cycle not yet known
    logic [9:0]  m_pend = 10'd0;
    logic [9:0]  m_data = 10'd0;
    int          m_credits = MAXC;
    logic [15:0] m_issued = 16'd0;
    int          m_reject = 0;

    // Expected outputs for the current cycle
    function automatic logic e_valid();
        return m_busy && !m_rej && m_tissue != 0 && m_tissue == cyc;
    endfunction

    function automatic logic e_err();
        return m_busy && m_rej && cyc == m_txfer + 1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_busy    <= 1'b0;
            m_rej     <= 1'b0;
            m_tissue  <= 0;
            m_data    <= 10'd0;
            m_credits <= MAXC;
            m_issued  <= 16'd0;
            m_reject  <= 0;
        end else begin
            m_issued <= m_issued + 16'(e_valid());
            if (e_err() && m_reject < 255) m_reject <= m_reject + 1;

            if (e_valid() && !result_ack)
                m_credits <= m_credits - 1;
            else if (!e_valid() && result_ack && m_credits < MAXC)
                m_credits <= m_credits + 1;

            if (!m_busy) begin
                if (host_valid) begin
                    m_busy   <= 1'b1;
                    m_rej    <= (host_op == 2'd3 && host_b == 4'd0);
                    m_txfer  <= cyc;
                    m_tissue <= 0;
                    m_pend   <= {host_op, host_b, host_a};
                end
            end else if (m_rej) begin
                if (cyc == m_txfer + 1) m_busy <= 1'b0;
            end else if (m_tissue == 0) begin
                if (m_credits != 0 && !cmd_full) begin
                    m_tissue <= cyc + 1;
                    m_data   <= m_pend;
                end
            end else if (cyc == m_tissue + 1) begin
                m_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rand_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (reset) begin
            check("m_host_ready", 32'(host_ready), 32'(!m_busy));
            check("m_cmd_valid",  32'(cmd_valid),  32'(e_valid()));
            check("m_err_div0",   32'(err_div0),   32'(e_err()));
            check("m_cmd_data",   32'(cmd_data),   32'(m_data));
            check("m_credits",    32'(credits),    32'(m_credits));
            check("m_issued_cnt", 32'(issued_cnt), 32'(m_issued));
            check("m_reject_cnt", 32'(reject_cnt), 32'(m_reject));
            if (cmd_valid)
                $display("[TB] t=%0t issue data=%b credits=%0d", $time, cmd_data, credits);
            if (err_div0)
                $display("[TB] t=%0t reject reject_cnt=%0d", $time, reject_cnt);
        end
    endtask

    // Advance to the next falling edge, check it, then drive this cycle's inputs.
    task automatic step();
        @(negedge clk);
        compare_model();
        if (rand_en) begin
            result_ack = ($urandom_range(0, 3) == 0);
            cmd_full   = ($urandom_range(0, 2) == 0);
        end else begin
            result_ack = 1'b0;
        end
    endtask

    // Offer one command. Returns at the falling edge of the cycle right after
    // the transfer edge.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        host_op = op;
        host_a = a;
        host_b = b;
        host_valid = 1'b1;
        while (!host_ready && n < 300) begin
            step();
            n++;
        end
        if (!host_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: host_ready got 0 expected 1 within 300 cycles");
            host_valid = 1'b0;
            return;
        end
        step();
        host_valid = 1'b0;
    endtask

    task automatic ack_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            result_ack = 1'b1;
            step();
        end
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequences
    // ------------------------------------------------------------------
    initial begin
        // Power-up reset, then reset again while a command waits in ARB
        step(); step(); step();
        @(posedge clk); #1 reset = 1'b1;
        step();
        cmd_full = 1'b1;
        send(2'd0, 4'd1, 4'd1);
        step(); step(); step();
        check("arb_wait_ready", 32'(host_ready), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        step(); step();
        cmd_full = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        step();
        check("rst_host_ready", 32'(host_ready), 32'd1);
        check("rst_credits",    32'(credits),    32'd7);
        check("rst_cmd_valid",  32'(cmd_valid),  32'd0);
        check("rst_cmd_data",   32'(cmd_data),   32'd0);
        check("rst_issued",     32'(issued_cnt), 32'd0);
        check("rst_reject",     32'(reject_cnt), 32'd0);
        step();

        // add a=3 b=5
        send(2'd0, 4'd3, 4'd5);
        check("add_no_early_valid", 32'(cmd_valid), 32'd0);
        step();
        check("add_valid", 32'(cmd_valid), 32'd1);
        check("add_data",  32'(cmd_data),  32'b00_0101_0011);
        step();
        check("add_valid_one_cycle", 32'(cmd_valid), 32'd0);
        check("add_credits", 32'(credits),    32'd6);
        check("add_issued",  32'(issued_cnt), 32'd1);
        step();

        // div by zero, then a legal div
        send(2'd3, 4'd9, 4'd0);
        check("div0_err",   32'(err_div0),  32'd1);
        check("div0_valid", 32'(cmd_valid), 32'd0);
        step();
        check("div0_reject", 32'(reject_cnt), 32'd1);
        check("div0_credits", 32'(credits),   32'd6);
        check("div0_ready",  32'(host_ready), 32'd1);
        send(2'd3, 4'd9, 4'd3);
        step();
        check("div_valid", 32'(cmd_valid), 32'd1);
        check("div_data",  32'(cmd_data),  32'b11_0011_1001);
        step();
        check("div_credits", 32'(credits), 32'd5);
        step();

        // Credit exhaustion
        ack_pulses(2);
        step();
        check("refill_credits", 32'(credits), 32'd7);
        for (int i = 0; i < 7; i++) send(2'd0, 4'(i), 4'(i + 1));
        step(); step(); step();
        check("exhaust_credits", 32'(credits), 32'd0);
        send(2'd1, 4'd15, 4'd1);
        for (int i = 0; i < 5; i++) step();
        check("starved_ready", 32'(host_ready), 32'd0);
        check("starved_valid", 32'(cmd_valid),  32'd0);
        result_ack = 1'b1;
        step();
        step();
        check("ack_issue_valid", 32'(cmd_valid), 32'd1);
        check("ack_issue_data",  32'(cmd_data),  32'b01_0001_1111);
        step();
        check("ack_issue_credits", 32'(credits), 32'd0);
        step();

        // cmd_full stall, with an ack landing in the issue cycle
        ack_pulses(3);
        cmd_full = 1'b1;
        send(2'd2, 4'd7, 4'd6);
        for (int i = 0; i < 5; i++) begin
            check("full_hold_valid", 32'(cmd_valid), 32'd0);
            step();
        end
        cmd_full = 1'b0;
        step();
        check("full_release_valid", 32'(cmd_valid), 32'd1);
        check("full_release_data",  32'(cmd_data),  32'b10_0110_0111);
        result_ack = 1'b1;
        step();
        check("issue_ack_credits", 32'(credits), 32'd3);
        step();

        // Reject counter saturation
        for (int i = 0; i < 300; i++) send(2'd3, 4'($urandom_range(0, 15)), 4'd0);
        step(); step();
        check("sat_reject", 32'(reject_cnt), 32'd255);
        check("sat_issued", 32'(issued_cnt), 32'd11);
        check("sat_credits", 32'(credits),   32'd3);

        // Random traffic against the model
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int gap;
            logic [3:0] b;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), b);
        end
        rand_en = 1'b0;
        cmd_full = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
